// File: rtl/regfile_seq_server.sv
// Register file served over a valid/ready handshake. A fixed RD1 -> RD2 -> WR
// sequence keeps the flop array to a single access per cycle.
module regfile_seq_server #(
  parameter int WIDTH = 32,
  parameter int ADDRW = 5
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [ADDRW-1:0] ReadRegister1,
  input  logic [ADDRW-1:0] ReadRegister2,
  input  logic [ADDRW-1:0] WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int NREG = 2 ** ADDRW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_mem [NREG];
  logic [ADDRW-1:0] r_ra1;
  logic [ADDRW-1:0] r_ra2;
  logic [ADDRW-1:0] r_wa;
  logic [WIDTH-1:0] r_wd;
  logic             r_we;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic [ADDRW-1:0] w_rd_addr;
  logic [WIDTH-1:0] w_rd_data;

  assign ReqReady  = r_req_ready;
  assign RespValid = r_resp_valid;
  assign ReadData1 = r_rd1;
  assign ReadData2 = r_rd2;

  // Sequencer: one state per array access, response held until accepted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ReqValid) begin
          w_state_nxt = S_RD1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD1:  w_state_nxt = S_RD2;
      S_RD2:  w_state_nxt = S_WR;
      S_WR:   w_state_nxt = S_RESP;
      S_RESP: begin
        if (RespReady) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The single read port is shared by RD1 and RD2; register 0 reads as zero.
  always_comb begin
    w_rd_addr = r_ra2;
    if (r_state == S_RD1) begin
      w_rd_addr = r_ra1;
    end else begin
      w_rd_addr = r_ra2;
    end
    if (w_rd_addr == '0) begin
      w_rd_data = '0;
    end else begin
      w_rd_data = r_mem[w_rd_addr];
    end
  end

  // State, handshake flags and latched request fields.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_ra1        <= '0;
      r_ra2        <= '0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_we         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      if ((r_state == S_IDLE) && ReqValid) begin
        r_ra1 <= ReadRegister1;
        r_ra2 <= ReadRegister2;
        r_wa  <= WriteRegister;
        r_wd  <= WriteData;
        r_we  <= RegWrite;
      end else begin
        r_ra1 <= r_ra1;
        r_ra2 <= r_ra2;
        r_wa  <= r_wa;
        r_wd  <= r_wd;
        r_we  <= r_we;
      end
    end
  end

  // Read results only move in RD1/RD2, so they stay stable through RESP.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      if (r_state == S_RD1) begin
        r_rd1 <= w_rd_data;
      end else begin
        r_rd1 <= r_rd1;
      end
      if (r_state == S_RD2) begin
        r_rd2 <= w_rd_data;
      end else begin
        r_rd2 <= r_rd2;
      end
    end
  end

  // Storage array: cleared on reset, written only in WR and never at address 0.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if ((r_state == S_WR) && r_we && (r_wa != '0)) begin
        r_mem[r_wa] <= r_wd;
      end else begin
        r_mem <= r_mem;
      end
    end
  end

endmodule

// File: tb/tb_regfile_seq_server.sv
// Directed bench for regfile_seq_server: handshake timing, read-before-write,
// write enable, decode isolation, register 0, stalls and mid-request reset.
module tb_regfile_seq_server;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int errors = 0;
  int checks = 0;

  regfile_seq_server #(.WIDTH(32), .ADDRW(5)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .RespValid(RespValid), .RespReady(RespReady),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 Clk = ~Clk;

  // Issues one request, waits for its response and accepts it.
  // lat = rising edges after the acceptance edge until RespValid is seen.
  task automatic do_req(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                        input logic [31:0] wd, input logic we,
                        output logic [31:0] d1, output logic [31:0] d2,
                        output int lat, output bit to);
    int n;
    to = 1'b0;
    n = 0;
    while (!ReqReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) to = 1'b1;
    ReqValid = 1'b1; ReadRegister1 = a1; ReadRegister2 = a2;
    WriteRegister = wa; WriteData = wd; RegWrite = we;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0; ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    WriteRegister = 5'd31; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
    lat = 0;
    while (!RespValid && lat < 20) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    if (lat >= 20) to = 1'b1;
    d1 = ReadData1;
    d2 = ReadData2;
    RespReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    RespReady = 1'b0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0; ReqValid = 1'b0; RespReady = 1'b0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; WriteRegister = 5'd0;
    WriteData = 32'd0; RegWrite = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b d1=%h d2=%h, want 1 0 0 0",
               ReqReady, RespValid, ReadData1, ReadData2);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d1, d2; int lat; bit to;
    do_req(5'd2, 5'd2, 5'd2, 32'd42, 1'b1, d1, d2, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL resp_latency_wr: got lat=%0d to=%b, want 3 0", lat, to);
    end
    checks++;
    if (d1 !== 32'd0 || d2 !== 32'd0) begin
      errors++; $display("FAIL read_before_write: got %0d %0d, want 0 0", d1, d2);
    end
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      errors++; $display("FAIL idle_after_resp: got rdy=%b vld=%b, want 1 0", ReqReady, RespValid);
    end
    do_req(5'd2, 5'd2, 5'd7, 32'd99, 1'b0, d1, d2, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL resp_latency_rd: got lat=%0d to=%b, want 3 0", lat, to);
    end
    checks++;
    if (d1 !== 32'd42 || d2 !== 32'd42) begin
      errors++; $display("FAIL write_visible: got %0d %0d, want 42 42", d1, d2);
    end
  endtask

  task automatic test_write_enable();
    logic [31:0] d1, d2; int lat; bit to;
    do_req(5'd0, 5'd0, 5'd2, 32'd15, 1'b1, d1, d2, lat, to);
    do_req(5'd0, 5'd0, 5'd2, 32'd16, 1'b0, d1, d2, lat, to);
    do_req(5'd2, 5'd0, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (to !== 1'b0 || d1 !== 32'd15 || d2 !== 32'd0) begin
      errors++; $display("FAIL write_enable: got %0d %0d to=%b, want 15 0 0", d1, d2, to);
    end
  endtask

  task automatic test_decode();
    logic [31:0] d1, d2; int lat; bit to;
    for (int r = 1; r < 32; r++) begin
      do_req(5'd0, 5'd0, 5'(r), 32'd0, 1'b1, d1, d2, lat, to);
    end
    do_req(5'd0, 5'd0, 5'd1, 32'd15, 1'b1, d1, d2, lat, to);
    for (int r = 2; r < 32; r += 2) begin
      do_req(5'(r), 5'(r + 1), 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
      checks++;
      if (to !== 1'b0 || d1 !== 32'd0 || d2 !== 32'd0) begin
        errors++; $display("FAIL decode_r%0d_r%0d: got %0d %0d, want 0 0", r, r + 1, d1, d2);
      end
    end
    do_req(5'd1, 5'd1, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (d1 !== 32'd15 || d2 !== 32'd15) begin
      errors++; $display("FAIL decode_r1: got %0d %0d, want 15 15", d1, d2);
    end
  endtask

  task automatic test_r0();
    logic [31:0] d1, d2; int lat; bit to;
    do_req(5'd0, 5'd0, 5'd0, 32'd1, 1'b1, d1, d2, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL r0_write_timing: got lat=%0d to=%b, want 3 0", lat, to);
    end
    do_req(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (d1 !== 32'd0 || d2 !== 32'd0) begin
      errors++; $display("FAIL r0_read: got %0d %0d, want 0 0", d1, d2);
    end
  endtask

  task automatic test_port2();
    logic [31:0] d1, d2; int lat; bit to;
    do_req(5'd0, 5'd0, 5'd17, 32'd5, 1'b1, d1, d2, lat, to);
    do_req(5'd0, 5'd0, 5'd3, 32'd8, 1'b1, d1, d2, lat, to);
    do_req(5'd17, 5'd3, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (d1 !== 32'd5 || d2 !== 32'd8) begin
      errors++; $display("FAIL port2_first: got %0d %0d, want 5 8", d1, d2);
    end
    do_req(5'd0, 5'd0, 5'd17, 32'd12, 1'b1, d1, d2, lat, to);
    do_req(5'd17, 5'd3, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (d1 !== 32'd12 || d2 !== 32'd8) begin
      errors++; $display("FAIL port2_decode: got %0d %0d, want 12 8", d1, d2);
    end
  endtask

  task automatic test_stall_and_reset();
    logic [31:0] d1, d2; int n; bit bad; logic [31:0] e1, e2; int lat; bit to;
    ReqValid = 1'b1; ReadRegister1 = 5'd17; ReadRegister2 = 5'd3;
    WriteRegister = 5'd3; WriteData = 32'd77; RegWrite = 1'b1;
    n = 0;
    while (!RespValid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n >= 20 || ReadData1 !== 32'd12 || ReadData2 !== 32'd8) begin
      errors++; $display("FAIL stall_resp: got n=%0d %0d %0d, want <20 12 8", n, ReadData1, ReadData2);
    end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (RespValid !== 1'b1 || ReqReady !== 1'b0 || ReadData1 !== 32'd12 || ReadData2 !== 32'd8)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL stall_hold: got vld=%b rdy=%b d1=%0d d2=%0d, want 1 0 12 8",
                         RespValid, ReqReady, ReadData1, ReadData2);
    end
    ReqValid = 1'b0; RespReady = 1'b1;
    @(posedge Clk); @(negedge Clk);
    RespReady = 1'b0;
    @(posedge Clk); @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      errors++; $display("FAIL no_second_accept: got rdy=%b vld=%b, want 1 0", ReqReady, RespValid);
    end
    do_req(5'd3, 5'd17, 5'd0, 32'd0, 1'b0, d1, d2, lat, to);
    checks++;
    if (d1 !== 32'd77 || d2 !== 32'd12) begin
      errors++; $display("FAIL stall_write_done: got %0d %0d, want 77 12", d1, d2);
    end
    // Accept at edge N, sit in RD2 after N+1, then reset at edge N+2.
    ReqValid = 1'b1; ReadRegister1 = 5'd3; ReadRegister2 = 5'd17;
    WriteRegister = 5'd5; WriteData = 32'd9; RegWrite = 1'b1;
    @(posedge Clk); @(negedge Clk);
    ReqValid = 1'b0;
    @(posedge Clk); @(negedge Clk);
    ResetN = 1'b0;
    @(posedge Clk); @(negedge Clk);
    ResetN = 1'b1;
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0 || ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got rdy=%b vld=%b d1=%h d2=%h, want 1 0 0 0",
                         ReqReady, RespValid, ReadData1, ReadData2);
    end
    bad = 1'b0;
    for (int r = 0; r < 32; r += 2) begin
      do_req(5'(r), 5'(r + 1), 5'd0, 32'd0, 1'b0, e1, e2, lat, to);
      if (to || e1 !== 32'd0 || e2 !== 32'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL regs_cleared: got a nonzero or timed-out read, want all 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_write_enable();
    test_decode();
    test_r0();
    test_port2();
    test_stall_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
